c_vote_tally: RTL and testbench

Synchronous back end for the 3x3 C-element voting array. It synchronizes the array's three per-group "any" (OR) and "majority" (2-of-3) outputs into the clock domain. It counts majority events per group and reports the first group to reach majority through a valid/ack handshake, like a buzzer. Before the next winner can be reported, the array must be fully released: every group's "any" line must return low.

---
 rtl/c_vote_tally.sv | 166 ++++++++++++++++
 tb/tb_c_vote_tally.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/c_vote_tally.sv
// Clock-domain back end for the 3x3 C-element voting array: synchronizes the
// per-group any/majority lines, counts majority events and reports the first winner.
module c_vote_tally #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int REL_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       grp_any,
    input  logic [2:0]       grp_maj,
    input  logic             ack,
    input  logic             clr,
    input  logic [1:0]       sel,
    output logic [1:0]       winner,
    output logic             winner_valid,
    output logic             armed,
    output logic [CNT_W-1:0] count_out,
    output logic [2:0]       sat
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WIN,
        S_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       REL_LAST = 4'(REL_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [1:0] lowest_idx(input logic [2:0] r);
        if (r[0])
            return 2'd0;
        else if (r[1])
            return 2'd1;
        else
            return 2'd2;
    endfunction

    logic [2:0]       any_sync [SYNC_STAGES];
    logic [2:0]       maj_sync [SYNC_STAGES];
    logic [2:0]       any_s;
    logic [2:0]       maj_s;
    logic [2:0]       maj_p;
    logic [2:0]       rise;
    logic [CNT_W-1:0] cnt [3];
    logic [CNT_W-1:0] cnt_sel;

    state_t     state, state_nxt;
    logic [1:0] winner_nxt;
    logic [3:0] rel_cnt, rel_nxt;

    // Synchronizer chains; the array lines are asynchronous to clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                any_sync[i] <= '0;
                maj_sync[i] <= '0;
            end
            maj_p <= '0;
        end else begin
            any_sync[0] <= grp_any;
            maj_sync[0] <= grp_maj;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                any_sync[i] <= any_sync[i-1];
                maj_sync[i] <= maj_sync[i-1];
            end
            maj_p <= maj_s;
        end
    end

    assign any_s = any_sync[SYNC_STAGES-1];
    assign maj_s = maj_sync[SYNC_STAGES-1];
    assign rise  = maj_s & ~maj_p;

    // Event counters run in every FSM state; clr takes priority over a rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < 3; g++)
                cnt[g] <= '0;
            sat <= '0;
        end else begin
            for (int g = 0; g < 3; g++) begin
                if (clr) begin
                    cnt[g] <= '0;
                    sat[g] <= 1'b0;
                end else if (rise[g]) begin
                    cnt[g] <= sat_inc(cnt[g]);
                    if (sat_inc(cnt[g]) == CNT_MAX)
                        sat[g] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    cnt_sel = cnt[0];
            2'd1:    cnt_sel = cnt[1];
            2'd2:    cnt_sel = cnt[2];
            default: cnt_sel = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_out <= '0;
        else
            count_out <= cnt_sel;
    end

    // Buzzer FSM: capture first winner, hold until ack, then wait for full release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            winner  <= 2'd0;
            rel_cnt <= '0;
        end else begin
            state   <= state_nxt;
            winner  <= winner_nxt;
            rel_cnt <= rel_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        winner_nxt = winner;
        rel_nxt    = rel_cnt;
        case (state)
            S_IDLE: begin
                if (|rise) begin
                    state_nxt  = S_WIN;
                    winner_nxt = lowest_idx(rise);
                end
            end
            S_WIN: begin
                if (ack) begin
                    state_nxt = S_RELEASE;
                    rel_nxt   = '0;
                end
            end
            S_RELEASE: begin
                if (any_s != 3'b000) begin
                    rel_nxt = '0;
                end else if (rel_cnt == REL_LAST) begin
                    state_nxt = S_IDLE;
                    rel_nxt   = '0;
                end else begin
                    rel_nxt = rel_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                rel_nxt   = '0;
            end
        endcase
    end

    assign armed        = (state == S_IDLE);
    assign winner_valid = (state == S_WIN);

endmodule

// File: tb/tb_c_vote_tally.sv
// Directed bench for c_vote_tally: winner capture, handshake, re-arm,
// counting in every state, saturation/clear and asynchronous reset.
module tb_c_vote_tally;

    logic       clk;
    logic       rst;
    logic [2:0] grp_any;
    logic [2:0] grp_maj;
    logic       ack;
    logic       clr;
    logic [1:0] sel;
    logic [1:0] winner;
    logic       winner_valid;
    logic       armed;
    logic [7:0] count_out;
    logic [2:0] sat;

    int n_checks = 0;
    int n_errors = 0;

    c_vote_tally #(
        .SYNC_STAGES(2),
        .CNT_W      (8),
        .REL_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .grp_any     (grp_any),
        .grp_maj     (grp_maj),
        .ack         (ack),
        .clr         (clr),
        .sel         (sel),
        .winner      (winner),
        .winner_valid(winner_valid),
        .armed       (armed),
        .count_out   (count_out),
        .sat         (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        grp_any = 3'b000;
        grp_maj = 3'b000;
        ack     = 1'b0;
        clr     = 1'b0;
        sel     = 2'd0;
        step();
        step();
        chk("rst_winner", 32'(winner), 32'd0);
        chk("rst_valid", 32'(winner_valid), 32'd0);
        chk("rst_armed", 32'(armed), 32'd1);
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        rst = 1'b0;
        step();

        // single event on group 1: valid after the third edge, count one edge later
        grp_maj = 3'b010;
        grp_any = 3'b010;
        sel     = 2'd1;
        step();
        chk("a_lat_e0", 32'(winner_valid), 32'd0);
        step();
        chk("a_lat_e1", 32'(winner_valid), 32'd0);
        step();
        chk("a_valid", 32'(winner_valid), 32'd1);
        chk("a_winner", 32'(winner), 32'd1);
        chk("a_armed", 32'(armed), 32'd0);
        chk("a_cnt_lag", 32'(count_out), 32'd0);
        step();
        chk("a_cnt1", 32'(count_out), 32'd1);

        // group 2 rises while in WIN: counted, winner unchanged
        grp_maj = 3'b110;
        step();
        step();
        grp_maj = 3'b010;
        repeat (4) step();
        chk("b_winner", 32'(winner), 32'd1);
        chk("b_valid", 32'(winner_valid), 32'd1);
        sel = 2'd2;
        step();
        chk("b_cnt2", 32'(count_out), 32'd1);

        // ack, then any held high keeps the FSM in RELEASE; a rise there is counted
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("c_valid", 32'(winner_valid), 32'd0);
        chk("c_winner", 32'(winner), 32'd1);
        grp_maj = 3'b100;
        grp_any = 3'b001;
        for (int i = 0; i < 6; i++) begin
            if (i == 2)
                grp_maj = 3'b000;
            step();
            chk("c_hold_armed", 32'(armed), 32'd0);
        end
        grp_any = 3'b000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("c_rel_wait", 32'(armed), 32'd0);
        end
        step();
        chk("c_rearm", 32'(armed), 32'd1);
        chk("c_winner_keep", 32'(winner), 32'd1);
        chk("c_valid_low", 32'(winner_valid), 32'd0);
        step();
        chk("c_cnt2", 32'(count_out), 32'd2);

        // clear, then groups 1 and 2 rise together in IDLE
        clr = 1'b1;
        step();
        clr = 1'b0;
        grp_maj = 3'b110;
        grp_any = 3'b110;
        step();
        step();
        chk("d_lat", 32'(winner_valid), 32'd0);
        step();
        chk("d_valid", 32'(winner_valid), 32'd1);
        chk("d_winner", 32'(winner), 32'd1);
        sel = 2'd1;
        step();
        chk("d_cnt1", 32'(count_out), 32'd1);
        sel = 2'd2;
        step();
        chk("d_cnt2", 32'(count_out), 32'd1);
        sel = 2'd0;
        step();
        chk("d_cnt0", 32'(count_out), 32'd0);
        sel = 2'd3;
        step();
        chk("d_sel3", 32'(count_out), 32'd0);

        // release back to IDLE
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("e_valid", 32'(winner_valid), 32'd0);
        grp_maj = 3'b000;
        grp_any = 3'b000;
        repeat (8) step();
        chk("e_armed", 32'(armed), 32'd1);

        // 256 rises on group 0: first one wins, counter saturates at 255
        for (int i = 0; i < 256; i++) begin
            grp_maj = 3'b001;
            step();
            step();
            grp_maj = 3'b000;
            step();
            step();
        end
        repeat (3) step();
        sel = 2'd0;
        step();
        chk("f_cnt_sat", 32'(count_out), 32'd255);
        chk("f_sat", 32'(sat), 32'd1);
        chk("f_winner", 32'(winner), 32'd0);
        chk("f_valid", 32'(winner_valid), 32'd1);

        // clr in the same cycle as a further rise on group 0
        grp_maj = 3'b001;
        step();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("g_sat_clr", 32'(sat), 32'd0);
        step();
        chk("g_cnt_clr", 32'(count_out), 32'd0);
        grp_maj = 3'b000;
        step();
        step();

        // new winner on group 2, then asynchronous reset between edges
        ack = 1'b1;
        step();
        ack = 1'b0;
        repeat (8) step();
        chk("h_armed", 32'(armed), 32'd1);
        sel     = 2'd2;
        grp_maj = 3'b100;
        step();
        step();
        chk("h_lat", 32'(winner_valid), 32'd0);
        step();
        chk("h_valid", 32'(winner_valid), 32'd1);
        chk("h_winner", 32'(winner), 32'd2);
        step();
        chk("h_cnt2", 32'(count_out), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("h_rst_winner", 32'(winner), 32'd0);
        chk("h_rst_valid", 32'(winner_valid), 32'd0);
        chk("h_rst_armed", 32'(armed), 32'd1);
        chk("h_rst_count", 32'(count_out), 32'd0);
        grp_maj = 3'b000;
        step();
        rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
